// File: rtl/fp16_pkg.sv
// Shared binary16 constants, FSM state encoding and result-class flag struct
// for the half-precision arithmetic units.
package fp16_pkg;
  localparam int EXP_W    = 5;
  localparam int MAN_W    = 10;
  localparam int BIAS     = 15;
  localparam int EMIN     = -14;
  localparam int EMIN_SUB = -24;

  localparam logic [8:0]  QNAN_DEFAULT = 9'h02A;
  localparam logic [4:0]  EXP_ALL1     = 5'h1F;
  localparam logic [14:0] INF_MAG      = 15'h7C00;
  localparam logic [14:0] ZERO_MAG     = 15'h0000;

  typedef enum logic [2:0] {IDLE, CHECK, DIV, PACK, DONE} state_e;

  typedef struct packed {
    logic snan;
    logic qnan;
    logic inf;
    logic zero;
    logic sub;
    logic norm;
  } fp_flags_t;
endpackage

// File: rtl/fp_class.sv
// Combinational binary16 operand classifier: exactly one class output is high.
module fp_class (
  input  logic [15:0] x_i,
  output logic        snan_o,
  output logic        qnan_o,
  output logic        inf_o,
  output logic        zero_o,
  output logic        subnormal_o,
  output logic        normal_o
);
  logic exp_all1, exp_zero, man_zero;
  logic unused_sign;

  assign exp_all1    = &x_i[14:10];
  assign exp_zero    = (x_i[14:10] == 5'd0);
  assign man_zero    = (x_i[9:0] == 10'd0);
  assign unused_sign = x_i[15];

  assign snan_o      = exp_all1 & ~man_zero & ~x_i[9];
  assign qnan_o      = exp_all1 & x_i[9];
  assign inf_o       = exp_all1 & man_zero;
  assign zero_o      = exp_zero & man_zero;
  assign subnormal_o = exp_zero & ~man_zero;
  assign normal_o    = ~exp_all1 & ~exp_zero;
endmodule

// File: rtl/fp_sig_div.sv
// Restoring radix-2 significand divider: {1,a_man}/{1,b_man}, one quotient bit
// per step, MSB first. last_o flags the step that produces the final bit.
module fp_sig_div #(
  parameter int QBITS = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [9:0]       a_man_i,
  input  logic [9:0]       b_man_i,
  output logic             last_o,
  output logic [QBITS-1:0] quo_o,
  output logic [11:0]      rem_o
);
  logic [11:0]      rem_q, rem_n, diff;
  logic [10:0]      div_q;
  logic [QBITS-1:0] quo_q;
  logic [3:0]       cnt_q;
  logic             ge;

  assign diff  = rem_q - {1'b0, div_q};
  assign ge    = (rem_q >= {1'b0, div_q});
  assign rem_n = ge ? diff : rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      div_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      rem_q <= {2'b01, a_man_i};
      div_q <= {1'b1, b_man_i};
      quo_q <= '0;
      cnt_q <= '0;
    end else if (step_i) begin
      // Remainder stays below 2*div, so the shift never loses a set bit.
      rem_q <= rem_n << 1;
      quo_q <= {quo_q[QBITS-2:0], ge};
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign last_o = (cnt_q == 4'(QBITS - 1));
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;
endmodule

// File: rtl/fp16_div.sv
// Iterative binary16 divider q = op_a / op_b with start/ready/valid handshake.
// FP16_DIV_ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
module fp16_div
  import fp16_pkg::*;
#(
  parameter int QBITS = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        ready_o,
  output logic        valid_o,
  output logic [15:0] q,
  output logic        sNaN_o,
  output logic        qNaN_o,
  output logic        infinity_o,
  output logic        zero_o,
  output logic        subnormal_o,
  output logic        normal_o,
  output state_e      dbg_state_o
);
  state_e           state_q;
  logic [15:0]      a_q, b_q, q_q;
  logic             sign_q, ready_q, valid_q;
  logic signed [6:0] e_q;
  fp_flags_t        flags_q;

  fp_flags_t ca, cb;
  fp_class u_cls_a (.x_i(a_q), .snan_o(ca.snan), .qnan_o(ca.qnan), .inf_o(ca.inf),
                    .zero_o(ca.zero), .subnormal_o(ca.sub), .normal_o(ca.norm));
  fp_class u_cls_b (.x_i(b_q), .snan_o(cb.snan), .qnan_o(cb.qnan), .inf_o(cb.inf),
                    .zero_o(cb.zero), .subnormal_o(cb.sub), .normal_o(cb.norm));

  logic             div_last;
  logic [QBITS-1:0] quo;
  logic [11:0]      rem;
  fp_sig_div #(.QBITS(QBITS)) u_sig_div (
    .clk(clk), .rst(rst),
    .load_i(state_q == CHECK), .step_i(state_q == DIV),
    .a_man_i(a_q[9:0]), .b_man_i(b_q[9:0]),
    .last_o(div_last), .quo_o(quo), .rem_o(rem)
  );

  // Exception screening; subnormal operands count as zero.
  logic      a_zero, b_zero, special;
  logic [15:0] spec_q;
  fp_flags_t spec_f;
  always_comb begin
    a_zero  = ca.zero | ca.sub;
    b_zero  = cb.zero | cb.sub;
    special = 1'b1;
    spec_q  = '0;
    spec_f  = '0;
    if (ca.snan | cb.snan) begin
      spec_q = ca.snan ? a_q : b_q;      spec_f.snan = 1'b1;
    end else if (ca.qnan | cb.qnan) begin
      spec_q = ca.qnan ? a_q : b_q;      spec_f.qnan = 1'b1;
    end else if ((ca.inf & cb.inf) | (a_zero & b_zero)) begin
      spec_q = {sign_q, EXP_ALL1, 1'b1, QNAN_DEFAULT}; spec_f.qnan = 1'b1;
    end else if (ca.inf | b_zero) begin
      spec_q = {sign_q, INF_MAG};        spec_f.inf = 1'b1;
    end else if (a_zero | cb.inf) begin
      spec_q = {sign_q, ZERO_MAG};       spec_f.zero = 1'b1;
    end else begin
      special = 1'b0;
    end
  end

  // Normalize, range-check and (optionally) round the finished quotient.
  logic [10:0]       sig, sig_r;
  logic              g, s, g_r, s_r;
  logic signed [6:0] e_n;
  logic [11:0]       full, shf, lost_mask;
  logic [3:0]        n_sh;
  logic [4:0]        exp_f;
  logic [14:0]       mag;
  fp_flags_t         pack_f;
  always_comb begin
    sig       = quo[12] ? quo[12:2] : quo[11:1];
    g         = quo[12] ? quo[1] : quo[0];
    s         = (quo[12] & quo[0]) | (rem != 12'd0);
    e_n       = quo[12] ? e_q : e_q - 7'sd1;
    n_sh      = 4'(EMIN - int'(e_n));
    full      = {sig, g};
    shf       = full >> n_sh;
    lost_mask = (12'd1 << n_sh) - 12'd1;
    if (int'(e_n) < EMIN) begin
      sig_r = shf[11:1];
      g_r   = shf[0];
      s_r   = s | (|(full & lost_mask));
      exp_f = 5'd0;
    end else begin
      sig_r = sig;
      g_r   = g;
      s_r   = s;
      exp_f = 5'(int'(e_n) + BIAS);
    end
    mag = {exp_f, sig_r[9:0]};
`ifdef FP16_DIV_ROUND_NEAREST_EN
    // Carry out of the mantissa bumps the exponent; 30 -> 31 yields infinity.
    mag = mag + {14'd0, g_r & (s_r | sig_r[0])};
`endif
    if (int'(e_n) > BIAS)          mag = INF_MAG;
    else if (int'(e_n) < EMIN_SUB) mag = ZERO_MAG;
    pack_f = '0;
    if (mag[14:10] == EXP_ALL1)    pack_f.inf  = 1'b1;
    else if (mag == ZERO_MAG)      pack_f.zero = 1'b1;
    else if (mag[14:10] == 5'd0)   pack_f.sub  = 1'b1;
    else                           pack_f.norm = 1'b1;
  end

  logic unused_pack;
`ifdef FP16_DIV_ROUND_NEAREST_EN
  assign unused_pack = ^{sig_r[10], ca.norm, cb.norm};
`else
  assign unused_pack = ^{sig_r[10], g_r, s_r, ca.norm, cb.norm};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      q_q     <= '0;
      flags_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      e_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          a_q     <= op_a;
          b_q     <= op_b;
          sign_q  <= op_a[15] ^ op_b[15];
          ready_q <= 1'b0;
          state_q <= CHECK;
        end
        CHECK: if (special) begin
          q_q     <= spec_q;
          flags_q <= spec_f;
          valid_q <= 1'b1;
          state_q <= DONE;
        end else begin
          e_q     <= $signed({2'b00, a_q[14:10]}) - $signed({2'b00, b_q[14:10]});
          state_q <= DIV;
        end
        DIV: if (div_last) state_q <= PACK;
        PACK: begin
          q_q     <= {sign_q, mag};
          flags_q <= pack_f;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o     = ready_q;
  assign valid_o     = valid_q;
  assign q           = q_q;
  assign sNaN_o      = flags_q.snan;
  assign qNaN_o      = flags_q.qnan;
  assign infinity_o  = flags_q.inf;
  assign zero_o      = flags_q.zero;
  assign subnormal_o = flags_q.sub;
  assign normal_o    = flags_q.norm;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_fp16_div.sv
// Self-checking bench for fp16_div: vector table through a scoreboard queue,
// plus hand-written mid-DIV restart, back-to-back and reset-abort sequences.
module tb_fp16_div;
  import fp16_pkg::*;

  localparam logic [5:0] F_SNAN = 6'b100000, F_QNAN = 6'b010000, F_INF = 6'b001000,
                         F_ZERO = 6'b000100, F_SUB  = 6'b000010, F_NORM = 6'b000001;
`ifdef FP16_DIV_ROUND_NEAREST_EN
  localparam logic [15:0] Q_10_3 = 16'h42AB;
`else
  localparam logic [15:0] Q_10_3 = 16'h42AA;
`endif

  logic clk = 1'b0, rst = 1'b1, start_i = 1'b0;
  logic [15:0] op_a = '0, op_b = '0, q;
  logic ready_o, valid_o, sNaN_o, qNaN_o, infinity_o, zero_o, subnormal_o, normal_o;
  state_e dbg_state_o;
  logic [5:0] flags;
  assign flags = {sNaN_o, qNaN_o, infinity_o, zero_o, subnormal_o, normal_o};

  fp16_div dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_a(op_a), .op_b(op_b),
    .ready_o(ready_o), .valid_o(valid_o), .q(q),
    .sNaN_o(sNaN_o), .qNaN_o(qNaN_o), .infinity_o(infinity_o), .zero_o(zero_o),
    .subnormal_o(subnormal_o), .normal_o(normal_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int total = 0, bad = 0;
  logic [21:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // scoreboard: every valid_o pulse pops one expected {q, flags}
  always @(negedge clk) begin
    if (!rst && valid_o) begin
      if (exp_q.size() == 0) chk("unexpected_valid", {16'd0, q}, 32'hFFFF_FFFF);
      else chk("result", {10'd0, q, flags}, {10'd0, exp_q.pop_front()});
    end
  end

  // driver tasks
  task automatic idle_ops();
    op_a = 16'($urandom_range(0, 16'hFFFF));
    op_b = 16'($urandom_range(0, 16'hFFFF));
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) chk("ready_timeout", {31'd0, ready_o}, 32'd1);
  endtask

  task automatic drive_start(input logic [15:0] a, input logic [15:0] b);
    start_i = 1'b1; op_a = a; op_b = b;
    @(posedge clk);
    #1 start_i = 1'b0;
    idle_ops();
  endtask

  // Called #1 after the n0-th edge counted from the accepting edge (=1).
  task automatic wait_valid(input int n0, input int lat, input string name);
    int n = n0;
    bit ready_bad = 0;
    while (!valid_o && n < 40) begin
      if (ready_o) ready_bad = 1;
      @(posedge clk);
      #1 n++;
    end
    chk({name, "_latency"}, n, lat);
    chk({name, "_ready_low"}, {31'd0, ready_bad | ready_o}, 32'd0);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] rq, input logic [5:0] rf, input int lat);
    exp_q.push_back({rq, rf});
    wait_ready();
    drive_start(a, b);
    wait_valid(1, lat, "op");
  endtask

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [5:0]  f;
    logic [5:0]  lat;
  } vec_t;
  localparam int NV = 18;
  vec_t vecs[NV];

  initial begin
    vecs[0]  = '{16'h3C00, 16'h4000, 16'h3800, F_NORM, 6'd16};
    vecs[1]  = '{16'h4900, 16'h4200, Q_10_3,   F_NORM, 6'd16};
    vecs[2]  = '{16'h7C00, 16'h7C00, 16'h7E2A, F_QNAN, 6'd2};
    vecs[3]  = '{16'h3C00, 16'h0000, 16'h7C00, F_INF,  6'd2};
    vecs[4]  = '{16'h7D00, 16'h3C00, 16'h7D00, F_SNAN, 6'd2};
    vecs[5]  = '{16'h8000, 16'h4000, 16'h8000, F_ZERO, 6'd2};
    vecs[6]  = '{16'h7BFF, 16'h0400, 16'h7C00, F_INF,  6'd16};
    vecs[7]  = '{16'h0400, 16'h4000, 16'h0200, F_SUB,  6'd16};
    vecs[8]  = '{16'h0400, 16'h7BFF, 16'h0000, F_ZERO, 6'd16};
    vecs[9]  = '{16'h0000, 16'h0000, 16'h7E2A, F_QNAN, 6'd2};
    vecs[10] = '{16'h7E00, 16'h3C00, 16'h7E00, F_QNAN, 6'd2};
    vecs[11] = '{16'h7E00, 16'h7C01, 16'h7C01, F_SNAN, 6'd2};
    vecs[12] = '{16'hC000, 16'h3C00, 16'hC000, F_NORM, 6'd16};
    vecs[13] = '{16'h3C00, 16'hFC00, 16'h8000, F_ZERO, 6'd2};
    vecs[14] = '{16'h0200, 16'h3C00, 16'h0000, F_ZERO, 6'd2};
    vecs[15] = '{16'h3C00, 16'h0001, 16'h7C00, F_INF,  6'd2};
    vecs[16] = '{16'h4400, 16'h4000, 16'h4000, F_NORM, 6'd16};
    vecs[17] = '{16'h3C00, 16'h3E00, 16'h3955, F_NORM, 6'd16};

    idle_ops();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {24'd0, ready_o, valid_o, flags}, {24'd0, 8'b1000_0000});
    chk("reset_q", {16'd0, q}, 32'd0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < NV; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].f, int'(vecs[i].lat));

    // Second start mid-DIV must be ignored; next start right after valid_o.
    exp_q.push_back({16'h3800, F_NORM});
    wait_ready();
    drive_start(16'h3C00, 16'h4000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    drive_start(16'h4900, 16'h4200);
    wait_valid(7, 16, "mid_start");
    @(negedge clk);
    @(negedge clk);
    chk("b2b_ready", {31'd0, ready_o}, 32'd1);
    exp_q.push_back({16'hC000, F_NORM});
    drive_start(16'hC400, 16'h4000);
    wait_valid(1, 16, "b2b");

    // Reset in DIV cycle 5 aborts the operation.
    wait_ready();
    drive_start(16'h3C00, 16'h4000);
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_state", {24'd0, ready_o, valid_o, flags}, {24'd0, 8'b1000_0000});
    chk("abort_q", {16'd0, q}, 32'd0);
    chk("abort_fsm", {29'd0, dbg_state_o}, {29'd0, IDLE});
    @(negedge clk) rst = 1'b0;
    repeat (25) @(posedge clk);
    run_op(16'h4900, 16'h4200, Q_10_3, F_NORM, 16);

    repeat (5) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
